// File: rtl/merge_arb_d0_d1_pkg.sv
// Shared widths, FSM encoding and the vc_id stamping helper for the D0/D1 merger.
package merge_arb_d0_d1_pkg;

  localparam int DATA_W = 6;
  localparam int VC_BIT = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_POP0 = 2'b01,
    ST_POP1 = 2'b10
  } state_t;

  function automatic logic [DATA_W-1:0] set_vc(input logic [DATA_W-1:0] d, input logic ch);
    logic [DATA_W-1:0] r;
    r         = d;
    r[VC_BIT] = ch;
    return r;
  endfunction

endpackage

// File: rtl/merge_arb_d0_d1_if.sv
// FIFO-side and downstream-side signals of the merger; master = merger, slave = surrounding logic.
interface merge_arb_d0_d1_if;
  import merge_arb_d0_d1_pkg::*;

  logic              fifo_empty_0;
  logic              fifo_empty_1;
  logic [DATA_W-1:0] data_in_0;
  logic [DATA_W-1:0] data_in_1;
  logic              valid_in_0;
  logic              valid_in_1;
  logic              pause;
  logic              pop_0;
  logic              pop_1;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [CNT_W-1:0]  cnt_0;
  logic [CNT_W-1:0]  cnt_1;
  logic              err;
  state_t            fsm_state;

  modport master (
    input  fifo_empty_0, fifo_empty_1, data_in_0, data_in_1, valid_in_0, valid_in_1, pause,
    output pop_0, pop_1, data_out, valid_out, cnt_0, cnt_1, err, fsm_state
  );

  modport slave (
    output fifo_empty_0, fifo_empty_1, data_in_0, data_in_1, valid_in_0, valid_in_1, pause,
    input  pop_0, pop_1, data_out, valid_out, cnt_0, cnt_1, err, fsm_state
  );

endinterface

// File: rtl/merge_arb_d0_d1_rr_arb2.sv
// Two-way round-robin grant, combinational, gated by pause and reset; last_grant
// is held in a register so D0 wins the first tie after reset.
module merge_arb_d0_d1_rr_arb2 (
  input  logic clk,
  input  logic reset_L,
  input  logic i_req_0,
  input  logic i_req_1,
  input  logic i_pause,
  output logic o_gnt_0,
  output logic o_gnt_1
);

  logic r_last_grant;
  logic w_gnt_0;
  logic w_gnt_1;

  always_comb begin
    w_gnt_0 = 1'b0;
    w_gnt_1 = 1'b0;
    if (reset_L && !i_pause) begin
      if (i_req_0 && i_req_1) begin
        w_gnt_0 = r_last_grant;
        w_gnt_1 = !r_last_grant;
      end else begin
        w_gnt_0 = i_req_0;
        w_gnt_1 = i_req_1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_last_grant <= 1'b1;
    end else if (w_gnt_0) begin
      r_last_grant <= 1'b0;
    end else if (w_gnt_1) begin
      r_last_grant <= 1'b1;
    end
  end

  assign o_gnt_0 = w_gnt_0;
  assign o_gnt_1 = w_gnt_1;

endmodule

// File: rtl/merge_arb_d0_d1.sv
// Round-robin merge of D0/D1 FIFOs into one stream; pop->valid_in 1 cycle, valid_in->valid_out 1 cycle.
// pause blocks new pops only; words already popped (at most 2) still drain to the output.
module merge_arb_d0_d1
  import merge_arb_d0_d1_pkg::*;
(
  input  logic               clk,
  input  logic               reset_L,
  merge_arb_d0_d1_if.master  bus
);

  logic              w_gnt_0;
  logic              w_gnt_1;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid_out;
  logic [CNT_W-1:0]  r_cnt_0;
  logic [CNT_W-1:0]  r_cnt_1;
  logic              r_err;

  merge_arb_d0_d1_rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset_L (reset_L),
    .i_req_0 (!bus.fifo_empty_0),
    .i_req_1 (!bus.fifo_empty_1),
    .i_pause (bus.pause),
    .o_gnt_0 (w_gnt_0),
    .o_gnt_1 (w_gnt_1)
  );

  always_comb begin
    w_state_nxt = ST_IDLE;
    if (w_gnt_0) begin
      w_state_nxt = ST_POP0;
    end else if (w_gnt_1) begin
      w_state_nxt = ST_POP1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // D0 has priority on a double valid; the D1 word is lost and the fault latched.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_cnt_0     <= '0;
      r_cnt_1     <= '0;
      r_err       <= 1'b0;
    end else begin
      if (bus.valid_in_0) begin
        r_data_out  <= set_vc(bus.data_in_0, 1'b0);
        r_valid_out <= 1'b1;
        r_cnt_0     <= r_cnt_0 + CNT_W'(1);
        if (bus.valid_in_1) begin
          r_err <= 1'b1;
        end
      end else if (bus.valid_in_1) begin
        r_data_out  <= set_vc(bus.data_in_1, 1'b1);
        r_valid_out <= 1'b1;
        r_cnt_1     <= r_cnt_1 + CNT_W'(1);
      end else begin
        r_data_out  <= '0;
        r_valid_out <= 1'b0;
      end
    end
  end

  assign bus.pop_0     = w_gnt_0;
  assign bus.pop_1     = w_gnt_1;
  assign bus.data_out  = r_data_out;
  assign bus.valid_out = r_valid_out;
  assign bus.cnt_0     = r_cnt_0;
  assign bus.cnt_1     = r_cnt_1;
  assign bus.err       = r_err;
  assign bus.fsm_state = r_state;

endmodule

// File: tb/tb_merge_arb_d0_d1.sv
// Directed bench for merge_arb_d0_d1: behavioural D0/D1 FIFOs answer pops one cycle later.
module tb_merge_arb_d0_d1;
  import merge_arb_d0_d1_pkg::*;

  logic clk = 1'b0;
  logic reset_L;
  int   n_chk = 0;
  int   n_err = 0;
  logic s_pop0, s_pop1;
  logic [5:0] q0[$];
  logic [5:0] q1[$];

  merge_arb_d0_d1_if bus();

  merge_arb_d0_d1 dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock: sample pops before the edge, then play the FIFOs' read response.
  task automatic cyc();
    @(negedge clk);
    s_pop0 = bus.pop_0;
    s_pop1 = bus.pop_1;
    @(posedge clk);
    #1;
    bus.valid_in_0 = 1'b0;
    bus.valid_in_1 = 1'b0;
    bus.data_in_0  = '0;
    bus.data_in_1  = '0;
    if (s_pop0 && q0.size() > 0) begin
      bus.data_in_0  = q0.pop_front();
      bus.valid_in_0 = 1'b1;
    end
    if (s_pop1 && q1.size() > 0) begin
      bus.data_in_1  = q1.pop_front();
      bus.valid_in_1 = 1'b1;
    end
    bus.fifo_empty_0 = (q0.size() == 0);
    bus.fifo_empty_1 = (q1.size() == 0);
    #2;
  endtask

  task automatic do_rst();
    reset_L = 1'b0;
    cyc();
    cyc();
    reset_L = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [5:0] exp2 [6];
    logic [5:0] t4_dat [10];
    logic       t4_vld [10];
    logic       t4_p0  [10];
    logic       t4_p1  [10];
    logic [5:0] e;
    int nvld, nbad;

    exp2   = '{6'h0A, 6'h15, 6'h2F, 6'h10, 6'h00, 6'h3A};
    t4_dat = '{6'h00, 6'h00, 6'h25, 6'h00, 6'h00, 6'h00, 6'h35, 6'h2F, 6'h36, 6'h00};
    t4_vld = '{0, 0, 1, 0, 0, 0, 1, 1, 1, 0};
    t4_p0  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    t4_p1  = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0};

    reset_L = 1'b0;
    s_pop0 = 1'b0;
    s_pop1 = 1'b0;
    bus.pause = 1'b0;
    bus.valid_in_0 = 1'b0;
    bus.valid_in_1 = 1'b0;
    bus.data_in_0 = '0;
    bus.data_in_1 = '0;
    q0 = '{6'h1A, 6'h3F, 6'h00};
    q1 = '{6'h05, 6'h10, 6'h2A};
    bus.fifo_empty_0 = 1'b0;
    bus.fifo_empty_1 = 1'b0;

    // Reset held with both FIFOs non-empty
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      chk("rst_pop0", bus.pop_0, 0);
      chk("rst_pop1", bus.pop_1, 0);
      chk("rst_vld", bus.valid_out, 0);
      chk("rst_dat", bus.data_out, 0);
      chk("rst_cnt0", bus.cnt_0, 0);
      chk("rst_cnt1", bus.cnt_1, 0);
      chk("rst_err", bus.err, 0);
    end

    // Alternating pops, vc bit stamped with source channel
    for (int k = 0; k < 9; k++) begin
      cyc();
      if (k == 0) reset_L = 1'b1;
      #1;
      chk("rr_pop0", bus.pop_0, (k < 6) && (k % 2 == 0));
      chk("rr_pop1", bus.pop_1, (k < 6) && (k % 2 == 1));
      chk("rr_vld", bus.valid_out, (k >= 2) && (k < 8));
      if (k >= 2 && k < 8) chk("rr_dat", bus.data_out, exp2[k-2]);
    end
    chk("rr_cnt0", bus.cnt_0, 3);
    chk("rr_cnt1", bus.cnt_1, 3);

    // Only D1 non-empty
    cyc();
    do_rst();
    for (int k = 0; k < 7; k++) begin
      if (k > 0) cyc();
      if (k == 0) begin
        q1 = '{6'h01, 6'h02, 6'h03, 6'h04};
        bus.fifo_empty_1 = 1'b0;
      end
      #1;
      chk("d1_pop0", bus.pop_0, 0);
      chk("d1_pop1", bus.pop_1, k < 4);
      chk("d1_vld", bus.valid_out, (k >= 2) && (k < 6));
      if (k >= 2 && k < 6) chk("d1_dat", bus.data_out, 32'(6'h11 + 6'(k - 2)));
      if (k == 1) chk("d1_state", bus.fsm_state, ST_POP1);
    end
    chk("d1_cnt1", bus.cnt_1, 4);
    chk("d1_cnt0", bus.cnt_0, 0);

    // Pause the cycle after a pop_0, then resume
    cyc();
    do_rst();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc();
      if (k == 0) begin
        q0 = '{6'h35, 6'h3F};
        q1 = '{6'h25, 6'h26};
        bus.fifo_empty_0 = 1'b0;
        bus.fifo_empty_1 = 1'b0;
      end
      bus.pause = (k >= 1) && (k <= 3);
      #1;
      chk("ps_pop0", bus.pop_0, t4_p0[k]);
      chk("ps_pop1", bus.pop_1, t4_p1[k]);
      chk("ps_vld", bus.valid_out, t4_vld[k]);
      chk("ps_dat", bus.data_out, t4_dat[k]);
    end
    chk("ps_cnt0", bus.cnt_0, 2);
    chk("ps_cnt1", bus.cnt_1, 2);

    // Double valid fault, then an unsolicited D1 word
    cyc();
    do_rst();
    bus.valid_in_0 = 1'b1;
    bus.data_in_0  = 6'h01;
    bus.valid_in_1 = 1'b1;
    bus.data_in_1  = 6'h02;
    cyc();
    #1;
    chk("fl_dat", bus.data_out, 6'h01);
    chk("fl_vld", bus.valid_out, 1);
    chk("fl_err", bus.err, 1);
    chk("fl_cnt0", bus.cnt_0, 1);
    chk("fl_cnt1", bus.cnt_1, 0);
    bus.valid_in_1 = 1'b1;
    bus.data_in_1  = 6'h0F;
    cyc();
    #1;
    chk("us_dat", bus.data_out, 6'h1F);
    chk("us_cnt1", bus.cnt_1, 1);
    chk("us_err", bus.err, 1);
    cyc();
    #1;
    chk("fl_vld_off", bus.valid_out, 0);
    chk("fl_err_stk", bus.err, 1);

    // 256 D0 packets: counter wraps
    do_rst();
    nvld = 0;
    nbad = 0;
    for (int k = 0; k < 260; k++) begin
      if (k > 0) cyc();
      if (k == 0) begin
        for (int i = 0; i < 256; i++) q0.push_back(6'(i));
        bus.fifo_empty_0 = 1'b0;
      end
      #1;
      if (k == 0) chk("wr_err_clr", bus.err, 0);
      if (bus.valid_out) begin
        nvld++;
        e = 6'(k - 2);
        e[VC_BIT] = 1'b0;
        if (bus.data_out !== e) nbad++;
      end
      if (k == 256) chk("wr_cnt_ff", bus.cnt_0, 8'hFF);
    end
    chk("wr_nvld", nvld, 256);
    chk("wr_nbad", nbad, 0);
    chk("wr_cnt0", bus.cnt_0, 0);

    // Reset mid-stream
    for (int i = 0; i < 10; i++) q0.push_back(6'h2C);
    bus.fifo_empty_0 = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    reset_L = 1'b0;
    #1;
    chk("mr_pop0", bus.pop_0, 0);
    q0.delete();
    cyc();
    #1;
    chk("mr_vld", bus.valid_out, 0);
    chk("mr_dat", bus.data_out, 0);
    chk("mr_cnt0", bus.cnt_0, 0);
    chk("mr_cnt1", bus.cnt_1, 0);
    reset_L = 1'b1;
    cyc();
    #1;
    chk("mr_idle_pop", bus.pop_0, 0);
    chk("mr_idle_vld", bus.valid_out, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
